// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor. A single 4-bit ripple-carry
//   stage is reused once per nibble, least-significant nibble first. The
//   carry passes between nibbles through a register. The full result is
//   offered with a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   op_a/op_b/sub are valid
//   in_ready   block is idle and can take an operation
//   op_a,op_b  WIDTH-bit operands
//   sub        0: A+B, 1: A-B
//   out_valid  result/carry_out/overflow are valid
//   out_ready  consumer takes the result
//   result     sum or difference, modulo 2^WIDTH
//   carry_out  final nibble carry (for subtraction, 1 = no borrow)
//   overflow   two's-complement signed overflow

module ripple_carry_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;          // holds B' (already inverted for sub)
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [3:0] a_nib, b_nib, sum_nib;
    logic       cout_nib;

    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];

    ripple_carry_4_bit u_rca (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (sum_nib),
        .cout (cout_nib)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        idx_d       = idx_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1: invert B here, seed carry with 1.
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = sum_nib;
                carry_d = cout_nib;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    idx_d       = '0;
                    carry_out_d = cout_nib;
                    // Carry into the MSB is recovered from the MSB sum bit.
                    overflow_d  = a_nib[3] ^ b_nib[3] ^ sum_nib[3] ^ cout_nib;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            idx_q       <= idx_d;
        end
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder/subtractor built around a single ripple_carry_4_bit stage. It sits directly upstream of that stage and feeds it one nibble of each operand per clock, least-significant first, carrying between nibbles through a register. It also collects each 4-bit sum into a result register and presents the full result with a valid/ready handshake. The trade is one 4-bit adder's area against WIDTH/4 cycles of latency.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8
- NIBBLES (local), WIDTH/4, number of adder passes per operation
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands and mode are valid
- in_ready  output  1  block can accept an operation
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- sub  input  1  0 computes A+B; 1 computes A−B
- out_valid  output  1  result, carry_out and overflow are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  sum or difference, modulo 2^WIDTH
- carry_out  output  1  final-nibble carry; for subtraction, 1 means no borrow
- overflow  output  1  two's-complement signed overflow

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid, the block captures A and B' at the next edge, where B' = sub ? ~op_b : op_b.
  - On the same edge: carry register is set to sub, nibble index to 0, state to RUN.
- **RUN:**
  - Each cycle the adder receives A[4i+3:4i], B'[4i+3:4i] and the carry register.
  - At the edge, the sum is written to result[4i+3:4i], the carry register takes cout, and i increments.
  - When i = NIBBLES−1 at the edge, the state moves to DONE.
  - On that same edge: carry_out takes the final cout, and overflow takes (carry into the MSB) XOR (final cout).
  - Carry into the MSB = A[WIDTH−1] ^ B'[WIDTH−1] ^ sum[WIDTH−1].
- **DONE:**
  - out_valid=1; result, carry_out and overflow are held stable.
  - On out_valid && out_ready the state returns to IDLE at that edge.
- **Single operation in flight:** in_ready=0 in RUN and DONE. in_valid is ignored there; operands and sub are not sampled after the accept edge.
- **Between operations:** result, carry_out and overflow keep their last values in IDLE. They are meaningful only while out_valid=1.
- **Width rule:** all arithmetic is modulo 2^WIDTH. No output wider than WIDTH except carry_out and overflow.

## Timing
- **Reset values:** state IDLE, in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0. Carry register and nibble index are 0.
- **Reset mid-operation:** reset in RUN or DONE abandons the operation. The block is in IDLE with all outputs at reset values one edge later, and no out_valid pulse is produced.
- **Reset priority:** rst has priority over every handshake in the same cycle.
- **Latency:** with the accept edge as E0, out_valid rises after edge E0+NIBBLES (4 cycles for WIDTH=16).
- **Throughput:** at most one operation per NIBBLES+2 cycles with out_ready held high. This is accept, NIBBLES RUN cycles, one DONE cycle, then back to IDLE.
- **Combinational paths:** in_ready and out_valid are decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- **Back-pressure:** while out_ready=0 in DONE, the block stays in DONE indefinitely with outputs unchanged.
- **Simultaneous events:**
  - in_valid in the same cycle as the out_valid && out_ready handshake is not accepted; it is accepted on the next cycle, in IDLE.
  - in_valid arriving during RUN is not accepted.

## Test plan
- **Add with inter-nibble carries:** A=0x1234, B=0x0FFF, sub=0 → result 0x2233, carry_out 0, overflow 0; out_valid exactly 4 edges after accept.
- **Full wrap:** A=0xFFFF, B=0x0001, sub=0 → result 0x0000, carry_out 1, overflow 0. Separately, A=0x7FFF, B=0x0001 → result 0x8000, carry_out 0, overflow 1.
- **Subtract:** A=0x0005, B=0x0007, sub=1 → result 0xFFFE, carry_out 0 (borrow), overflow 0. Separately, A=0x8000, B=0x0001, sub=1 → result 0x7FFF, carry_out 1, overflow 1.
- **Back-pressure:**
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - Required: result stable, in_ready=0, new operands ignored.
  - After out_ready=1: returns to IDLE, then accepts the pending in_valid and returns its correct result.
- **Reset mid-run:** assert rst for one cycle at the second RUN cycle → next cycle state IDLE, out_valid=0, result=0, in_ready=1. No stale result appears; a following 0x0001+0x0001 gives 0x0002.
- **Back-to-back streaming:** 20 random operations with in_valid and out_ready held high, compared against a reference model for both modes. Accepts are spaced exactly 6 cycles apart for WIDTH=16.
